dmem_arbiter: RTL and testbench

Sequences and shares the single-port data memory (dmem) between two requesters. Port 0 is the CPU load/store stage and port 1 is the loader/debug master. The block drives dmem's address, write data, readmode and writemode strobes. It holds each access for a fixed memory latency and returns read data with a one-cycle acknowledge. Arbitration is fixed priority to port 0, with a starvation guard for port 1.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arb_pick.sv | 41 ++++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM state encoding,
// port-select constants and a counter-width function.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection for the data-memory arbiter: fixed priority to port 0,
// with a streak counter that forces a port-1 grant after STARVE_MAX port-0 wins.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SW         = clog2(STARVE_MAX + 1)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          p0_req,
  input  logic          p1_req,
  input  logic          take,
  output logic          sel,
  output logic [SW-1:0] streak
);

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    sel = PORT1;
    if (p0_req && (!p1_req || (streak < SW'(STARVE_MAX))))
      sel = PORT0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      streak <= '0;
    end else if (take) begin
      if (sel == PORT1)
        streak <= '0;
      else if (p1_req)
        streak <= streak + SW'(1);
      else
        streak <= '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the CPU load/store port (0) and the
// loader/debug port (1); each access holds one strobe for MEM_LAT cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_ack,
  output logic          p0_err,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_ack,
  output logic          p1_err,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_readmode,
  output logic          mem_writemode,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = clog2(MEM_LAT);
  localparam int SW = clog2(STARVE_MAX + 1);

  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic            take, sel;
  logic [SW-1:0]   streak;
  logic            lat_port, lat_we, lat_mis;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic [DW-1:0]   rdata0, rdata1;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic            last_beat, active;

  // Requests are only looked at while idle.
  assign take = (state == IDLE) && (p0_req || p1_req);

  dmem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_pick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .p0_req  (p0_req),
    .p1_req  (p1_req),
    .take    (take),
    .sel     (sel),
    .streak  (streak)
  );

  assign win_we    = (sel == PORT0) ? p0_we    : p1_we;
  assign win_addr  = (sel == PORT0) ? p0_addr  : p1_addr;
  assign win_wdata = (sel == PORT0) ? p0_wdata : p1_wdata;
  assign last_beat = (cnt == CW'(MEM_LAT - 1));
  assign active    = (state == ACCESS) && !lat_mis;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (take) nxt = ACCESS;
      ACCESS:  if (lat_mis || last_beat) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // NOTE: the latched request fields are reset too; they feed outputs through
  // gating only, but a clean reset keeps the ack/err decode deterministic.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lat_port  <= PORT0;
      lat_we    <= 1'b0;
      lat_mis   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      if (take) begin
        lat_port  <= sel;
        lat_we    <= win_we;
        lat_addr  <= win_addr;
        lat_wdata <= win_wdata;
        lat_mis   <= (win_addr[1:0] != 2'b00);
      end
      if ((state == ACCESS) && (nxt == ACCESS)) cnt <= cnt + CW'(1);
      else                                      cnt <= '0;
      // Read data is captured on the final strobe edge for the owning port only.
      if (active && last_beat && !lat_we) begin
        if (lat_port == PORT0) rdata0 <= mem_rdata;
        else                   rdata1 <= mem_rdata;
      end
    end
  end

  always_comb begin
    p0_gnt        = 1'b0;
    p1_gnt        = 1'b0;
    p0_ack        = 1'b0;
    p1_ack        = 1'b0;
    p0_err        = 1'b0;
    p1_err        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_readmode  = 1'b0;
    mem_writemode = 1'b0;
    if ((state == ACCESS) && (cnt == '0)) begin
      p0_gnt = (lat_port == PORT0);
      p1_gnt = (lat_port == PORT1);
    end
    if (active) begin
      mem_addr      = lat_addr;
      mem_wdata     = lat_wdata;
      mem_readmode  = !lat_we;
      mem_writemode = lat_we;
    end
    if (state == RESP) begin
      p0_ack = (lat_port == PORT0);
      p1_ack = (lat_port == PORT1);
      p0_err = (lat_port == PORT0) && lat_mis;
      p1_err = (lat_port == PORT1) && lat_mis;
    end
  end

  assign p0_rdata = rdata0;
  assign p1_rdata = rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers push expected responses on
// acceptance, an independent monitor checks acks, grants and strobes.
module tb_dmem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        Clk, Reset_n;
  logic        p0_req, p0_we, p0_gnt, p0_ack, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_ack, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_readmode, mem_writemode;

  dmem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX), .AW(32), .DW(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_readmode(mem_readmode),
    .mem_writemode(mem_writemode), .mem_rdata(mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory behind the arbiter: unwritten words read back as index*0x111.
  function automatic logic [31:0] seed_word(input int idx);
    return 32'(idx) * 32'h0000_0111;
  endfunction

  logic [31:0] dmem    [128];
  logic        written [128];
  logic [31:0] ref_mem [128];

  always @(posedge Clk) begin
    if (mem_writemode) begin
      dmem[mem_addr[8:2]]    <= mem_wdata;
      written[mem_addr[8:2]] <= 1'b1;
    end
  end
  assign mem_rdata = (written[mem_addr[8:2]] === 1'b1) ? dmem[mem_addr[8:2]]
                                                       : seed_word(int'(mem_addr[8:2]));

  // Reference model and scoreboard.
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [31:0] model_rd [2];
  int          gnt_log[$];

  function automatic void push_exp(input int port, input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata);
    exp_t e;
    e.err = (addr[1:0] != 2'b00);
    e.lat = e.err ? 1 : MEM_LAT;
    if (!e.err) begin
      if (we) ref_mem[addr[8:2]] = wdata;
      else    model_rd[port]     = ref_mem[addr[8:2]];
    end
    e.rdata = model_rd[port];
    if (port == 0) q0.push_back(e);
    else           q1.push_back(e);
  endfunction

  int cyc = 0;
  logic s_req0, s_req1;
  always @(posedge Clk) begin
    cyc++;
    s_req0 = p0_req;
    s_req1 = p1_req;
  end

  // Monitor: grant legality and arbitration rule, ack scoreboard, strobe shape.
  int run = 0;
  int slen = 0;
  int gnt_cyc [2];
  always @(negedge Clk) begin
    exp_t e;
    int   act_port, exp_port;
    if (!Reset_n) begin
      run  = 0;
      slen = 0;
    end else begin
      if (p0_gnt || p1_gnt) begin
        check("gnt_overlap", 32'(p0_gnt && p1_gnt), 32'd0);
        act_port = p1_gnt ? 1 : 0;
        if (s_req0 && s_req1)  exp_port = (run < STARVE_MAX) ? 0 : 1;
        else if (s_req0)       exp_port = 0;
        else if (s_req1)       exp_port = 1;
        else                   exp_port = 2;
        check("gnt_port", 32'(act_port), 32'(exp_port));
        if (act_port == 1)  run = 0;
        else if (s_req1)    run++;
        else                run = 0;
        gnt_cyc[act_port] = cyc;
        gnt_log.push_back(act_port);
      end
      if (p0_ack) begin
        if (q0.size() == 0) check("p0_ack_unexpected", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          check("p0_err", 32'(p0_err), 32'(e.err));
          check("p0_rdata", p0_rdata, e.rdata);
          check("p0_latency", 32'(cyc - gnt_cyc[0]), 32'(e.lat));
        end
      end
      if (p1_ack) begin
        if (q1.size() == 0) check("p1_ack_unexpected", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("p1_err", 32'(p1_err), 32'(e.err));
          check("p1_rdata", p1_rdata, e.rdata);
          check("p1_latency", 32'(cyc - gnt_cyc[1]), 32'(e.lat));
        end
      end
      if (mem_readmode && mem_writemode) check("strobe_both", 32'd1, 32'd0);
      if (mem_readmode || mem_writemode) slen++;
      else if (slen > 0) begin
        check("strobe_len", 32'(slen), 32'(MEM_LAT));
        slen = 0;
      end
    end
  end

  // Drivers: hold req until gnt, then record the expected response.
  task automatic issue(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int gc);
    int n;
    logic g;
    if (port == 0) begin p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
    else           begin p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
    n = 0;
    g = 1'b0;
    while (!g && n < 100) begin
      @(negedge Clk);
      n++;
      g = (port == 0) ? p0_gnt : p1_gnt;
    end
    gc = cyc;
    if (!g) check("gnt_timeout", 32'd0, 32'd1);
    else    push_exp(port, we, addr, wdata);
  endtask

  task automatic release_port(input int port);
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 300) begin
      @(negedge Clk);
      n++;
    end
    @(negedge Clk);
    check("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic run_random(input int port, input int count);
    int gc;
    logic        we;
    logic [31:0] addr;
    for (int i = 0; i < count; i++) begin
      we   = 1'($urandom_range(0, 1));
      addr = ((port == 1) ? 32'h100 : 32'h0) + (32'($urandom_range(0, 63)) << 2);
      if ($urandom_range(0, 3) == 0) addr = addr + 32'($urandom_range(1, 3));
      issue(port, we, addr, $urandom, gc);
      release_port(port);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  int g1, g2;
  int exp_order [10];

  initial begin
    for (int i = 0; i < 128; i++) begin
      written[i] = 1'b0;
      ref_mem[i] = seed_word(i);
    end
    model_rd[0] = '0;
    model_rd[1] = '0;
    {p0_req, p0_we, p0_addr, p0_wdata} = '0;
    {p1_req, p1_we, p1_addr, p1_wdata} = '0;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_ctrl", 32'({p0_gnt, p0_ack, p0_err, p1_gnt, p1_ack, p1_err,
                             mem_readmode, mem_writemode}), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_rdata", p0_rdata | p1_rdata | mem_wdata, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Single port-0 read at 0x4.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h4;
    @(negedge Clk);
    check("t1_gnt", 32'(p0_gnt), 32'd1);
    if (p0_gnt) push_exp(0, 1'b0, 32'h4, 32'h0);
    p0_req = 1'b0;
    check("t1_readmode_c1", 32'({mem_readmode, mem_writemode}), 32'b10);
    check("t1_mem_addr", mem_addr, 32'h4);
    @(negedge Clk);
    check("t1_gnt_pulse", 32'(p0_gnt), 32'd0);
    check("t1_readmode_c2", 32'(mem_readmode), 32'd1);
    @(negedge Clk);
    check("t1_ack", 32'(p0_ack), 32'd1);
    check("t1_rdata", p0_rdata, 32'h0000_0111);
    check("t1_strobe_off", 32'(mem_readmode), 32'd0);
    @(negedge Clk);
    check("t1_idle_addr", mem_addr, 32'd0);

    // Port-1 write to 0x8.
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h8; p1_wdata = 32'hDEAD_BEEF;
    @(negedge Clk);
    check("t2_gnt", 32'(p1_gnt), 32'd1);
    if (p1_gnt) push_exp(1, 1'b1, 32'h8, 32'hDEAD_BEEF);
    p1_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("t2_writemode", 32'({mem_readmode, mem_writemode}), 32'b01);
      check("t2_mem_addr", mem_addr, 32'h8);
      check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      @(negedge Clk);
    end
    check("t2_ack", 32'(p1_ack), 32'd1);
    check("t2_rdata_kept", p1_rdata, 32'd0);
    drain();

    // Misaligned port-0 read: no strobe, ack+err one cycle after gnt.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h3;
    @(negedge Clk);
    check("t4_gnt", 32'(p0_gnt), 32'd1);
    if (p0_gnt) push_exp(0, 1'b0, 32'h3, 32'h0);
    p0_req = 1'b0;
    check("t4_no_strobe_c1", 32'({mem_readmode, mem_writemode}), 32'd0);
    @(negedge Clk);
    check("t4_ack_err", 32'({p0_ack, p0_err}), 32'b11);
    check("t4_no_strobe_c2", 32'({mem_readmode, mem_writemode}), 32'd0);
    drain();

    // Both ports requesting continuously: starvation guard order.
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    gnt_log.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) issue(0, 1'b0, 32'(i) << 2, 32'h0, g1);
        release_port(0);
      end
      begin
        for (int i = 0; i < 2; i++) issue(1, 1'b0, 32'h100 + (32'(i) << 2), 32'h0, g2);
        release_port(1);
      end
    join
    drain();
    check("t3_gnt_count", 32'(gnt_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < gnt_log.size(); i++)
      check("t3_order", 32'(gnt_log[i]), 32'(exp_order[i]));

    // Back-to-back port-0 reads, spaced MEM_LAT+2 cycles.
    issue(0, 1'b0, 32'h0, 32'h0, g1);
    issue(0, 1'b0, 32'h4, 32'h0, g2);
    release_port(0);
    check("t6_spacing", 32'(g2 - g1), 32'(MEM_LAT + 2));
    drain();

    // Reset during the second ACCESS cycle abandons the access.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    @(negedge Clk);
    p0_req = 1'b0;
    @(negedge Clk);
    check("t5_strobe_before", 32'(mem_readmode), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("t5_strobe_async", 32'({mem_readmode, mem_writemode}), 32'd0);
    check("t5_addr_async", mem_addr, 32'd0);
    model_rd[0] = '0;
    model_rd[1] = '0;
    @(negedge Clk);
    check("t5_no_ack", 32'({p0_ack, p1_ack}), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    check("t5_rdata_cleared", p0_rdata, 32'd0);
    issue(0, 1'b0, 32'h10, 32'h0, g1);
    release_port(0);
    drain();

    // Randomized traffic from both ports in disjoint address regions.
    fork
      run_random(0, 40);
      run_random(1, 40);
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
